// File: rtl/ddr3_rdcap_ring.sv
// Burst ring between the DDR3 PHY capture stage and the read-return path.
// Latency: a burst's first beat is valid the cycle after the edge that captured its final pair.
// Backpressure: rd_ready low holds rd_data/rd_last; capture is never stalled, and listens that would overflow are dropped.
//
// Ports: clk, reset_n (async active-low); listen arms one burst; cap_valid/cap_rise/cap_fall
// carry one rise/fall pair per cycle; rd_valid/rd_ready/rd_data/rd_last stream committed
// beats; pending/stored report ring occupancy; listen_err/strobe_err are sticky, cleared by err_clr.
// Optional: define DDR3_RDCAP_BC4_EN to add listen_bc4 (burst-chop 4 per armed burst).
module ddr3_rdcap_ring #(
    parameter int DW     = 16,
    parameter int BL     = 8,
    parameter int NBURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      listen,
`ifdef DDR3_RDCAP_BC4_EN
    input  logic                      listen_bc4,
`endif
    input  logic                      cap_valid,
    input  logic [DW-1:0]             cap_rise,
    input  logic [DW-1:0]             cap_fall,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [DW-1:0]             rd_data,
    output logic                      rd_last,
    output logic [$clog2(NBURST):0]   pending,
    output logic [$clog2(NBURST):0]   stored,
    output logic                      listen_err,
    output logic                      strobe_err,
    input  logic                      err_clr
);

    localparam int SW  = $clog2(NBURST);
    localparam int BW  = $clog2(BL);
    localparam int CW  = SW + 1;
    localparam int CW1 = CW + 1;
    localparam int AW  = SW + BW;

    localparam logic [BW-1:0] BEAT_LAST = BW'(BL - 1);
    localparam logic [BW-1:0] PAIR_LAST = BW'(BL - 2);
`ifdef DDR3_RDCAP_BC4_EN
    localparam logic [BW-1:0] BC4_BEAT_LAST = BW'(3);
    localparam logic [BW-1:0] BC4_PAIR_LAST = BW'(2);
`endif

    // Beat storage: slot-major, index = {slot, beat}. Not reset.
    logic [DW-1:0] mem [NBURST*BL];

    logic [SW-1:0] wslot, rslot, rslot_n;
    logic [BW-1:0] wbeat, rbeat, rbeat_n;
    logic [CW-1:0] stored_n;
    logic [CW:0]   occ, limit;
    logic          cap_en, cap_drop, wr_done, rd_fire, rd_done, arm_ok, listen_drop;
    logic [AW-1:0] widx_rise, widx_fall, rd_idx;

`ifdef DDR3_RDCAP_BC4_EN
    // One chop flag per slot; armed bursts occupy slots wslot, wslot+1, ... in arm order.
    logic [NBURST-1:0] chop;
    logic [SW-1:0]     arm_slot;
    assign arm_slot = wslot + pending[SW-1:0];
    assign wr_done  = cap_en && (wbeat == (chop[wslot] ? BC4_PAIR_LAST : PAIR_LAST));
    assign rd_last  = (rbeat == (chop[rslot] ? BC4_BEAT_LAST : BEAT_LAST));
`else
    assign wr_done  = cap_en && (wbeat == PAIR_LAST);
    assign rd_last  = (rbeat == BEAT_LAST);
`endif

    assign cap_en   = cap_valid && (pending != '0);
    assign cap_drop = cap_valid && (pending == '0);

    assign rd_valid = (stored != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_done  = rd_fire && rd_last;

    // Full check on pre-edge counts; a last beat leaving this cycle frees its slot in time.
    assign occ         = {1'b0, pending} + {1'b0, stored};
    assign limit       = CW1'(NBURST) + CW1'(rd_done);
    assign arm_ok      = listen && (occ < limit);
    assign listen_drop = listen && !arm_ok;

    assign widx_rise = {wslot, wbeat};
    assign widx_fall = {wslot, wbeat | BW'(1)};

    assign rbeat_n  = rd_done ? '0 : (rd_fire ? rbeat + BW'(1) : rbeat);
    assign rslot_n  = rd_done ? rslot + SW'(1) : rslot;
    assign stored_n = stored + CW'(wr_done) - CW'(rd_done);
    assign rd_idx   = {rslot_n, rbeat_n};

    // Storage write. The registered read below looks ahead one edge; it never needs a
    // bypass because the reader can only point into bursts whose beats were written at
    // an earlier edge (a burst committing now is entered at beat 0, written pairs ago).
    always_ff @(posedge clk) begin
        if (cap_en) begin
            mem[widx_rise] <= cap_rise;
            mem[widx_fall] <= cap_fall;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wslot      <= '0;
            wbeat      <= '0;
            rslot      <= '0;
            rbeat      <= '0;
            pending    <= '0;
            stored     <= '0;
            rd_data    <= '0;
            listen_err <= 1'b0;
            strobe_err <= 1'b0;
        end else begin
            if (cap_en) begin
                if (wr_done) begin
                    wbeat <= '0;
                    wslot <= wslot + SW'(1);
                end else begin
                    wbeat <= wbeat + BW'(2);
                end
            end
            rbeat   <= rbeat_n;
            rslot   <= rslot_n;
            pending <= pending + CW'(arm_ok) - CW'(wr_done);
            stored  <= stored_n;
            // Hold while nothing is committed so uncommitted data is never shown.
            if (stored_n != '0) begin
                rd_data <= mem[rd_idx];
            end
            // A fresh error beats err_clr in the same cycle.
            listen_err <= listen_drop | (listen_err & ~err_clr);
            strobe_err <= cap_drop | (strobe_err & ~err_clr);
        end
    end

`ifdef DDR3_RDCAP_BC4_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chop <= '0;
        end else if (arm_ok) begin
            chop[arm_slot] <= listen_bc4;
        end
    end
`endif

endmodule

// File: doc/ddr3_rdcap_ring.md
Name: ddr3_rdcap_ring

Overview:
- Parametrised, fully synchronous successor to the 8-deep strobe-clocked DDR3 read ring buffer.
- Accepts rise/fall data pairs already re-timed into the controller clock domain by the PHY capture stage.
- Groups the pairs into bursts armed by listen pulses and stores up to NBURST complete bursts in a ring.
- Streams committed bursts to the read-return path one beat per cycle with a valid/ready handshake.

Parameters:
- DW, 16, data beat width in bits.
- BL, 8, beats per burst; even, 4 or 8.
- NBURST, 4, ring depth in bursts; power of 2, at least 2. Storage is NBURST*BL beats.

Ports:
- clk  in  1  controller clock.
- reset_n  in  1  asynchronous active-low reset.
- listen  in  1  one-cycle pulse: arm capture of one burst.
- cap_valid  in  1  a rise/fall pair is present this cycle.
- cap_rise  in  DW  even beat (rising-edge data).
- cap_fall  in  DW  odd beat (falling-edge data).
- rd_ready  in  1  consumer accepts a beat.
- rd_valid  out  1  rd_data holds a committed beat.
- rd_data  out  DW  output beat.
- rd_last  out  1  rd_data is the final beat of its burst.
- pending  out  clog2(NBURST)+1  bursts armed but not yet complete.
- stored  out  clog2(NBURST)+1  bursts committed but not fully read.
- listen_err  out  1  sticky: listen pulse dropped because the ring was full.
- strobe_err  out  1  sticky: cap_valid seen while nothing was armed; data dropped.
- err_clr  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (reset_n low, asynchronous): pointers, beat counter, pending, stored, rd_valid, rd_last, listen_err and strobe_err all go to 0.
  - rd_data is 0 after reset.
  - Storage contents are don't-care.
  - Reset asserted mid-burst discards the partial burst and every stored burst.
- Arming:
  - A listen pulse with pending+stored < NBURST increments pending.
  - Otherwise the pulse is ignored and listen_err is set.
- Capture, when cap_valid and pending > 0:
  - cap_rise is written at beat slot wbeat and cap_fall at wbeat+1 of the write burst slot wslot; wbeat then advances by 2.
  - When wbeat reaches BL-2, the pair completes the burst: wbeat returns to 0, wslot increments modulo NBURST, pending decrements and stored increments, all in the same edge.
- Dropped capture: cap_valid with pending == 0 drops the pair and sets strobe_err. Storage and counters are unchanged.
- Simultaneous events:
  - listen in the same cycle as a burst completion leaves pending unchanged.
  - A completion in the same cycle as the read of a last beat leaves stored unchanged.
  - The full check for listen uses pre-edge values, plus 1 if a last beat is being read that cycle.
- Latency: the first beat of a burst presents rd_valid=1 on the cycle after the edge that captured its final pair. Data is never exposed before its burst commits.
- Read:
  - rd_valid = (stored > 0).
  - rd_data is storage[rslot][rbeat], registered output, and holds stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready, rbeat increments.
  - rd_last = (rbeat == BL-1). On the last beat, rbeat returns to 0, rslot increments modulo NBURST and stored decrements.
  - Back-to-back bursts stream with no bubble.
- Wrap-around: wslot and rslot wrap from NBURST-1 to 0. Full and empty are resolved by stored, never by pointer comparison.
- Errors: err_clr clears both flags. A new error in the same cycle as err_clr wins, so the flag stays set.

Optional Feature:
- Macro: DDR3_RDCAP_BC4_EN.
- When defined:
  - Adds input listen_bc4 (1 bit), sampled with listen, and a per-slot chop flag queue of NBURST entries.
  - A chopped burst completes after 4 beats (2 pairs).
  - On read, rd_last asserts at rbeat == 3, then the reader advances to the next slot.
  - Upper slot beats are not written and never presented.
- When undefined: port is absent, all bursts are BL beats, no chop queue exists.

Test Plan:
- Single burst: DW=16, BL=8. listen; 4 pairs (0x0000/0x0001 ... 0x0006/0x0007) with rd_ready=1 -> rd_valid rises the cycle after the 4th pair; 8 beats 0x0000..0x0007; rd_last only on 0x0007; pending and stored return to 0.
- Fill and overflow: NBURST=4, rd_ready=0. 5 listens, 4 full bursts -> stored=4; 5th listen sets listen_err; pending=0. err_clr then clears the flag.
- Spurious strobe: cap_valid=1 with pending=0 -> strobe_err=1, stored stays 0, no write occurs. A later armed burst reads back correct data.
- Backpressure and wrap: 6 bursts through NBURST=4 with rd_ready toggling 1,0,1,0 -> all 48 beats in order, rd_data stable while stalled, rslot and wslot wrap.
- Simultaneous events: listen in the same cycle as a burst's final pair, and that cycle's read of a last beat -> pending and stored unchanged; no beat lost.
- Reset mid-burst: reset_n low after 2 pairs with 1 burst stored -> all outputs 0. A post-reset burst reads back cleanly.
- With DDR3_RDCAP_BC4_EN: listen with listen_bc4=1, 2 pairs -> 4 beats out, rd_last on beat 3; the next BL8 burst follows without a gap.
